hazard_forward_ctrl: RTL

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It replaces the purely combinational forwarding unit and adds a cycle-counted stall engine for load-use hazards. It also provides a no-forwarding mode that stalls until the producer has retired, and branch-flush abort of pending stalls. It sits beside the ID/EX register and drives the EX operand muxes plus the PC, IF/ID and ID/EX hold/bubble controls.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/fwd_select.sv | 28 ++
 rtl/hazard_forward_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - forward-select codes, FSM state type and default widths for the hazard controller
package hazard_pkg;

   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   localparam int DEFAULT_REG_ADDR_W = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      STALL = 1'b1
   } haz_state_t;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - combinational forward-code generator for one EX operand
module fwd_select
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
   input  logic                  en,
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  exmem_reg_write,
   input  logic [REG_ADDR_W-1:0] exmem_wb_reg,
   input  logic                  memwb_reg_write,
   input  logic [REG_ADDR_W-1:0] memwb_wb_reg,
   output logic [1:0]            fwd
);

   // The younger producer (EX/MEM) holds the newer value, so it wins.
   always_comb begin
      fwd = FWD_REGFILE;
      if (en) begin
         if (exmem_reg_write && (exmem_wb_reg != '0) && (exmem_wb_reg == src)) begin
            fwd = FWD_EXMEM;
         end else if (memwb_reg_write && (memwb_wb_reg != '0) && (memwb_wb_reg == src)) begin
            fwd = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX forwarding plus counted load-use / no-forward stall engine
// Optional saturating stall_cycles counter built when HAZ_STATS_EN is defined.
module hazard_forward_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W   = DEFAULT_REG_ADDR_W,
   parameter int LOAD_BUBBLES = 1,
   parameter int CNT_W        = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  forward_en,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic [REG_ADDR_W-1:0] idex_rs,
   input  logic [REG_ADDR_W-1:0] idex_rt,
   input  logic                  idex_reg_write,
   input  logic                  idex_mem_read,
   input  logic [REG_ADDR_W-1:0] idex_wb_reg,
   input  logic                  exmem_reg_write,
   input  logic [REG_ADDR_W-1:0] exmem_wb_reg,
   input  logic                  memwb_reg_write,
   input  logic [REG_ADDR_W-1:0] memwb_wb_reg,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  pc_hold,
   output logic                  ifid_hold,
   output logic                  idex_bubble,
   output logic                  stall_busy
`ifdef HAZ_STATS_EN
   ,
   output logic [15:0]           stall_cycles
`endif
);

   function automatic logic id_match(
      input logic [REG_ADDR_W-1:0] dest,
      input logic                  we,
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] rt,
      input logic                  uses_rs,
      input logic                  uses_rt
   );
      return we && (dest != '0) && ((uses_rs && (dest == rs)) || (uses_rt && (dest == rt)));
   endfunction

   haz_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] need_n;
   logic             m_ex, m_mem, m_wb;
   logic             stall;

   fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
      .en              (forward_en),
      .src             (idex_rs),
      .exmem_reg_write (exmem_reg_write),
      .exmem_wb_reg    (exmem_wb_reg),
      .memwb_reg_write (memwb_reg_write),
      .memwb_wb_reg    (memwb_wb_reg),
      .fwd             (forward_a)
   );

   fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
      .en              (forward_en),
      .src             (idex_rt),
      .exmem_reg_write (exmem_reg_write),
      .exmem_wb_reg    (exmem_wb_reg),
      .memwb_reg_write (memwb_reg_write),
      .memwb_wb_reg    (memwb_wb_reg),
      .fwd             (forward_b)
   );

   assign m_ex  = id_match(idex_wb_reg,  idex_reg_write,  id_rs, id_rt, id_uses_rs, id_uses_rt);
   assign m_mem = id_match(exmem_wb_reg, exmem_reg_write, id_rs, id_rt, id_uses_rs, id_uses_rt);
   assign m_wb  = id_match(memwb_wb_reg, memwb_reg_write, id_rs, id_rt, id_uses_rs, id_uses_rt);

   // Without forwarding the consumer waits for the producer to retire (no write-through regfile).
   always_comb begin
      need_n = '0;
      if (forward_en) begin
         if (m_ex && idex_mem_read) need_n = CNT_W'(LOAD_BUBBLES);
      end else if (m_ex) begin
         need_n = CNT_W'(3);
      end else if (m_mem) begin
         need_n = CNT_W'(2);
      end else if (m_wb) begin
         need_n = CNT_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      if (reset || flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (need_n != '0) begin
                  stall = 1'b1;
                  if (need_n > CNT_W'(1)) begin
                     state_nxt = STALL;
                     cnt_nxt   = need_n - CNT_W'(1);
                  end
               end
            end
            STALL: begin
               stall = 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign pc_hold     = stall;
   assign ifid_hold   = stall;
   assign idex_bubble = stall;
   assign stall_busy  = (state == STALL) && !reset;

`ifdef HAZ_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule
